// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU op codes, the decoded
// control-bit bundle and the ID/EX stage state encoding.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  // ALU operation codes carried through ex_aluop
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h7;

  // Decoded control bits that travel with the instruction into EX
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // EX register occupancy; BUBBLE is an empty slot created by a load-use hazard
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// is read by the instruction decode is presenting. Register 0 never hazards.
module id_ex_hazard #(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_valid,
  output logic              lu_stall
);
  import mips_pkg::*;

  logic [REG_AW-1:0] src [2];
  logic [1:0]        src_hit;

  assign src[0] = id_rs;
  assign src[1] = id_rt;

  // One comparator per source operand of the decode instruction
  for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
    assign src_hit[gi] = (src[gi] == ex_dst);
  end

  assign lu_stall = ex_valid && ex_memread && (ex_dst != '0) && (|src_hit) && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, one-bubble load-use
// interlock, branch flush and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W,
  parameter int CNT_W   = mips_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [DATA_W-1:0]  id_data1,
  input  logic [DATA_W-1:0]  id_data2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               id_alusrc,
  input  logic               id_regdst,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               lu_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);
  import mips_pkg::*;

  ex_state_e          state_reg;
  ctrl_t              ctrl_reg;
  ctrl_t              ctrl_next;
  logic [DATA_W-1:0]  data1_reg;
  logic [DATA_W-1:0]  data2_reg;
  logic [DATA_W-1:0]  imm_reg;
  logic [REG_AW-1:0]  rs_reg;
  logic [REG_AW-1:0]  rt_reg;
  logic [REG_AW-1:0]  dst_reg;
  logic [REG_AW-1:0]  dst_next;
  logic [ALUOP_W-1:0] aluop_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               advance;
  logic               clear_slot;

  assign ctrl_next = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                       memtoreg: id_memtoreg, alusrc: id_alusrc};
  assign dst_next  = id_regdst ? id_rd : id_rt;

  assign ex_valid = (state_reg == ST_FULL);
  // EX slot can take a new entry when empty or when EX consumes it now
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !lu_stall && !flush;

  id_ex_hazard #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid   (ex_valid),
    .ex_memread (ctrl_reg.memread),
    .ex_dst     (dst_reg),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_valid   (id_valid),
    .lu_stall   (lu_stall)
  );

  // Slot becomes empty on flush, on a hazard bubble, or when nothing is offered
  assign clear_slot = flush || (advance && (lu_stall || !id_valid));

  // EX register: flush > load-use bubble > accept > drain > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      ctrl_reg  <= CTRL_NONE;
      data1_reg <= '0;
      data2_reg <= '0;
      imm_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      dst_reg   <= '0;
      aluop_reg <= '0;
    end else if (clear_slot) begin
      state_reg <= (!flush && lu_stall) ? ST_BUBBLE : ST_EMPTY;
      ctrl_reg  <= CTRL_NONE;
      data1_reg <= '0;
      data2_reg <= '0;
      imm_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      dst_reg   <= '0;
      aluop_reg <= '0;
    end else if (advance) begin
      state_reg <= ST_FULL;
      ctrl_reg  <= ctrl_next;
      data1_reg <= id_data1;
      data2_reg <= id_data2;
      imm_reg   <= id_imm;
      rs_reg    <= id_rs;
      rt_reg    <= id_rt;
      dst_reg   <= dst_next;
      aluop_reg <= id_aluop;
    end
  end

  // Saturating count of inserted load-use bubbles; a flush cancels the bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!flush && advance && lu_stall && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign ex_data1    = data1_reg;
  assign ex_data2    = data2_reg;
  assign ex_imm      = imm_reg;
  assign ex_rs       = rs_reg;
  assign ex_rt       = rt_reg;
  assign ex_dst      = dst_reg;
  assign ex_regwrite = ctrl_reg.regwrite;
  assign ex_memread  = ctrl_reg.memread;
  assign ex_memwrite = ctrl_reg.memwrite;
  assign ex_memtoreg = ctrl_reg.memtoreg;
  assign ex_alusrc   = ctrl_reg.alusrc;
  assign ex_aluop    = aluop_reg;
  assign bubble_cnt  = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, a transaction-level
// model of the EX slot checked every cycle, and literal spot checks.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  // control bundle order: {regwrite, memread, memwrite, memtoreg, alusrc}
  localparam int CTL_R  = 5'b10000;
  localparam int CTL_LD = 5'b11011;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_data1, id_data2, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
  logic [OW-1:0] id_aluop;
  logic          flush;
  logic          ex_ready;
  logic          ex_valid;
  logic [DW-1:0] ex_data1, ex_data2, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_dst;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [OW-1:0] ex_aluop;
  logic          lu_stall;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_aluop(id_aluop), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .lu_stall(lu_stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the EX slot holds, as one record
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d1, d2, imm;
    logic [AW-1:0] rs, rt, dst;
    logic [4:0]    ctl;
    logic [OW-1:0] aluop;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  verbose = 1'b1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ex(input string name, input ex_t act, input ex_t exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t r;
    r = {ex_valid, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_dst,
         ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop};
    return r;
  endfunction

  // The decode instruction as it should appear once in EX
  function automatic ex_t id_as_ex();
    ex_t r;
    r.v     = 1'b1;
    r.d1    = id_data1;
    r.d2    = id_data2;
    r.imm   = id_imm;
    r.rs    = id_rs;
    r.rt    = id_rt;
    r.dst   = id_regdst ? id_rd : id_rt;
    r.ctl   = {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc};
    r.aluop = id_aluop;
    return r;
  endfunction

  // A load in EX whose non-zero destination the decode instruction reads
  function automatic logic m_hazard();
    return id_valid && m_ex.v && m_ex.ctl[3] && (m_ex.dst != '0) &&
           (m_ex.dst == id_rs || m_ex.dst == id_rt);
  endfunction

  function automatic logic m_can_move();
    return !m_ex.v || ex_ready;
  endfunction

  // Model: what occupies EX after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= '0;
      m_cnt <= 0;
    end else if (flush) begin
      m_ex <= '0;
    end else if (m_can_move()) begin
      if (m_hazard()) begin
        m_ex <= '0;
        if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      end else if (id_valid) begin
        m_ex <= id_as_ex();
      end else begin
        m_ex <= '0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check_ex("ex_regs", dut_ex(), m_ex);
    check("lu_stall", lu_stall, m_hazard());
    check("id_ready", id_ready, m_can_move() && !m_hazard() && !flush);
    check("bubble_cnt", bubble_cnt, m_cnt);
    if (verbose && ex_valid && ex_ready)
      $display("[TB] t=%0t EX consumes dst=%0d data1=%h aluop=%0d", $time, ex_dst, ex_data1, ex_aluop);
  end

  task automatic idle();
    id_valid = 1'b0; id_data1 = '0; id_data2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc} = 5'b0;
    id_regdst = 1'b0; id_aluop = '0;
  endtask

  task automatic put(input int unsigned d1, input int unsigned d2, input int unsigned imm,
                     input int rs, input int rt, input int rd, input int ctl,
                     input int op, input int regdst);
    id_valid = 1'b1;
    id_data1 = d1; id_data2 = d2; id_imm = imm;
    id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc} = 5'(ctl);
    id_aluop = OW'(op); id_regdst = regdst[0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_id_ready", id_ready, 1);
    check("rst_lu_stall", lu_stall, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    rst_n = 1'b1;
    tick();

    // basic capture with rd destination
    put(32'h11, 32'h22, 32'h4, 1, 7, 3, CTL_R, 2, 1);
    tick(); idle();
    check("t1_ex_valid", ex_valid, 1);
    check("t1_ex_data1", ex_data1, 32'h11);
    check("t1_ex_data2", ex_data2, 32'h22);
    check("t1_ex_dst", ex_dst, 3);

    // load-use: one bubble, consumer enters EX the cycle after
    put(32'h100, 32'h200, 32'h8, 2, 5, 9, CTL_LD, 0, 0);
    tick();
    check("t2_load_dst", ex_dst, 5);
    put(32'h33, 32'h44, 32'h0, 5, 6, 7, CTL_R, 1, 1);
    check("t2_lu_stall", lu_stall, 1);
    check("t2_id_ready", id_ready, 0);
    tick();
    check("t2_bubble_valid", ex_valid, 0);
    check("t2_bubble_cnt", bubble_cnt, 1);
    check("t2_stall_clear", lu_stall, 0);
    check("t2_ready_again", id_ready, 1);
    tick(); idle();
    check("t2_consumer_valid", ex_valid, 1);
    check("t2_consumer_data1", ex_data1, 32'h33);
    check("t2_consumer_dst", ex_dst, 7);

    // load to register 0 never hazards
    put(32'h5, 32'h6, 32'h0, 1, 0, 4, CTL_LD, 0, 0);
    tick();
    put(32'h7, 32'h8, 32'h0, 0, 0, 8, CTL_R, 3, 1);
    check("t3_lu_stall", lu_stall, 0);
    check("t3_id_ready", id_ready, 1);
    tick(); idle();
    check("t3_bubble_cnt", bubble_cnt, 1);
    check("t3_ex_dst", ex_dst, 8);

    // downstream stall holds EX for 3 cycles
    put(32'hA0, 32'hA1, 32'h0, 1, 2, 10, CTL_R, 4, 1);
    tick();
    ex_ready = 1'b0;
    put(32'hB0, 32'hB1, 32'h0, 3, 4, 11, CTL_R, 5, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_data1", ex_data1, 32'hA0);
      check("t4_hold_dst", ex_dst, 10);
      check("t4_id_ready", id_ready, 0);
    end
    ex_ready = 1'b1;
    #1;
    check("t4_release_ready", id_ready, 1);
    tick(); idle();
    check("t4_next_data1", ex_data1, 32'hB0);
    check("t4_next_dst", ex_dst, 11);

    // flush together with a load-use hazard
    put(32'hC0, 32'hC1, 32'h4, 1, 5, 0, CTL_LD, 0, 0);
    tick();
    flush = 1'b1;
    put(32'hD0, 32'hD1, 32'h0, 5, 2, 12, CTL_R, 1, 1);
    check("t5_lu_stall", lu_stall, 1);
    check("t5_id_ready", id_ready, 0);
    tick();
    flush = 1'b0; idle();
    check("t5_ex_valid", ex_valid, 0);
    check("t5_regwrite", ex_regwrite, 0);
    check("t5_memread", ex_memread, 0);
    check("t5_data1", ex_data1, 0);
    check("t5_bubble_cnt", bubble_cnt, 1);
    tick();

    // asynchronous reset mid-stream, no clock edge needed
    put(32'hDEADBEEF, 32'h1, 32'h2, 3, 4, 13, CTL_R, 6, 1);
    tick();
    check("t6_pre_valid", ex_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", ex_valid, 0);
    check("t6_rst_data1", ex_data1, 0);
    check("t6_rst_dst", ex_dst, 0);
    check("t6_rst_regwrite", ex_regwrite, 0);
    check("t6_rst_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); idle();
    check("t6_first_valid", ex_valid, 1);
    check("t6_first_data1", ex_data1, 32'hDEADBEEF);

    // 2^CW + 2 hazards to saturate the counter
    verbose = 1'b0;
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      put(32'(i), 32'h0, 32'h0, 1, 5, 0, CTL_LD, 0, 0);
      tick();
      put(32'h0, 32'h0, 32'h0, 5, 2, 3, CTL_R, 0, 1);
      tick();
      tick();
      if (i == CNT_MAX - 2) check("t7_below_max", bubble_cnt, CNT_MAX - 1);
      if (i == CNT_MAX - 1) check("t7_at_max", bubble_cnt, CNT_MAX);
    end
    idle();
    tick();
    check("t7_saturated", bubble_cnt, CNT_MAX);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
